vfpu_norm: RTL and testbench
============================

VFPU_NORM -- requirements
Module: vfpu_norm

Interface
REQ-001 SHALL take widths from hwpe_ctrl_vfpu_package constants, not module parameters:
- FP_EXP_WIDTH, 8, packed exponent width.
- FP_MANT_WIDTH, 23, packed fraction width.
- FP_EXP_PRENORM_WIDTH, 10, signed pre-normalization exponent width.
- FP_MANT_PRENORM_WIDTH, 48, pre-normalization mantissa width.
REQ-002 SHALL have a single clock domain with synchronous, active-high reset, and SHALL expose these ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  pre-normalized operand valid.
- ready_o  out  1  block can accept an operand.
- signPreNorm_i  in  1  result sign from the adder.
- exponentPreNorm_i  in  FP_EXP_PRENORM_WIDTH  signed biased exponent.
- mantissaPreNorm_i  in  FP_MANT_PRENORM_WIDTH  bit47 carry, bit46 implied one, 45:23 fraction, 22 guard, 21 round, 20 sticky, 19:0 zero.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  32  packed IEEE-754 single.
- overflow_o  out  1  result saturated to infinity.
- underflow_o  out  1  result flushed to zero.
- inexact_o  out  1  any of guard, round or sticky nonzero after normalization.

Function
REQ-003 SHALL use an FSM with states IDLE, NORM, ROUND and OUT.
- ready_o = 1 only in IDLE.
- valid_o = 1 only in OUT.
REQ-004 SHALL register all inputs and move IDLE->NORM when valid_i & ready_o.
REQ-005 In NORM, if bit47 = 1, SHALL shift the mantissa right by 1, increment the exponent, OR the shifted-out bit into sticky, then go to ROUND.
REQ-006 In NORM, if the mantissa is all zero, SHALL go to ROUND with a zero flag set and no shifting.
REQ-007 In NORM, if bit47 = 0 and bit46 = 0, SHALL shift left until bit46 = 1 and decrement the exponent by the shift count; shift mechanism per Configuration.
REQ-008 In ROUND, SHALL round to nearest, ties to even:
- increment = G & (R | S | LSB), where LSB = bit23.
- A fraction carry-out SHALL increment the exponent and zero the fraction.
REQ-009 In ROUND, SHALL apply range handling:
- exponent >= 255: result {sign, 8'hFF, 0}, overflow_o = 1.
- exponent <= 0: result {sign, 0, 0}, underflow_o = 1.
- zero flag set: result 32'h0000_0000, all flags 0.
REQ-010 SHALL go ROUND->OUT unconditionally; OUT->IDLE on ready_i.
REQ-011 SHALL hold result_o and all flags stable while valid_o = 1 and ready_i = 0.
REQ-012 SHALL keep flags valid only while valid_o = 1; flags SHALL be 0 otherwise.
REQ-013 SHALL ignore valid_i outside IDLE and SHALL NOT capture or lose data there.
REQ-014 SHALL allow no overlap: one result in flight; the next operand is accepted no earlier than the cycle after the OUT handshake.

Reset
REQ-015 On rst_i = 1, SHALL enter IDLE on the next edge from any state, including mid-NORM or OUT, and SHALL discard the in-flight operand.
REQ-016 Reset values SHALL be:
- ready_o = 1, valid_o = 0.
- result_o = 0.
- overflow_o = underflow_o = inexact_o = 0.
- internal mantissa, exponent and shift counter = 0.

Configuration
REQ-017 Macro VFPU_NORM_LZC_EN SHALL select the NORM shift mechanism.
- Defined: NORM uses a leading-zero counter and a barrel shifter and takes exactly 1 cycle; valid_o rises on the 3rd edge after acceptance.
- Undefined: NORM shifts left 1 bit per cycle until bit46 = 1 (max 24 cycles); the right-shift and zero cases take 1 cycle.
- Results SHALL be bit-identical in both modes.

Verification
REQ-018 1.0+1.0: exp 127, mant 48'h8000_0000_0000, sign 0 -> result_o 32'h4000_0000, flags 0, valid_o on 3rd edge after accept (LZC_EN).
REQ-019 Cancellation: exp 127, mant 48'h0000_0080_0000 -> result_o 32'h3400_0000.
- With LZC_EN, latency 3.
- Without LZC_EN, NORM lasts 23 cycles.
REQ-020 Ties-to-even:
- exp 127, mant 48'h4000_0040_0000 -> 32'h3F80_0000, inexact_o 1.
- Adding bit23 (48'h4000_00C0_0000) -> 32'h3F80_0002.
REQ-021 Overflow: exp 254, mant 48'h8000_0000_0000 -> 32'h7F80_0000, overflow_o 1; negative sign -> 32'hFF80_0000.
REQ-022 Backpressure: ready_i = 0 for 5 cycles in OUT -> result_o, flags and valid_o stable; valid_i pulses ignored.
REQ-023 Reset during NORM (LZC_EN undefined, 10 cycles into the shift) -> next cycle IDLE, ready_o 1, valid_o 0, result_o 0.

Source files
------------

// File: rtl/hwpe_ctrl_vfpu_package.sv
// Shared width constants for the vector FPU datapath.
//   FP_EXP_WIDTH          packed exponent width
//   FP_MANT_WIDTH         packed fraction width
//   FP_EXP_PRENORM_WIDTH  signed pre-normalization exponent width
//   FP_MANT_PRENORM_WIDTH pre-normalization mantissa width
package hwpe_ctrl_vfpu_package;

  localparam int unsigned FP_EXP_WIDTH          = 8;
  localparam int unsigned FP_MANT_WIDTH         = 23;
  localparam int unsigned FP_EXP_PRENORM_WIDTH  = 10;
  localparam int unsigned FP_MANT_PRENORM_WIDTH = 48;

endpackage

// File: rtl/vfpu_norm.sv
// vfpu_norm: normalizes and rounds (nearest, ties to even) the raw adder
// result into an IEEE-754 single, one operand in flight at a time.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   operand handshake (ready_o only in IDLE)
//   signPreNorm_i       result sign
//   exponentPreNorm_i   signed biased exponent
//   mantissaPreNorm_i   [47] carry, [46] implied one, [45:23] fraction,
//                       [22] guard, [21] round, [20] sticky, [19:0] zero
//   valid_o / ready_i   result handshake (valid_o only in OUT)
//   result_o            packed single
//   overflow_o          saturated to infinity
//   underflow_o         flushed to zero
//   inexact_o           guard/round/sticky nonzero after normalization
//
// Build option:
//   VFPU_NORM_LZC_EN  defined: leading-zero count + barrel shift, NORM is
//                     one cycle. Undefined: NORM shifts left one bit per
//                     cycle. Results are identical in both builds.
module vfpu_norm
  import hwpe_ctrl_vfpu_package::*;
(
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    valid_i,
  output logic                                    ready_o,
  input  logic                                    signPreNorm_i,
  input  logic signed [FP_EXP_PRENORM_WIDTH-1:0]  exponentPreNorm_i,
  input  logic        [FP_MANT_PRENORM_WIDTH-1:0] mantissaPreNorm_i,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic        [31:0]                      result_o,
  output logic                                    overflow_o,
  output logic                                    underflow_o,
  output logic                                    inexact_o
);

  localparam int unsigned MW       = FP_MANT_PRENORM_WIDTH;
  // Two guard bits so right-shift increments and large left shifts never wrap.
  localparam int unsigned EW       = FP_EXP_PRENORM_WIDTH + 2;
  localparam int unsigned CW       = 6;
  localparam int unsigned BIT_CRY  = MW - 1;
  localparam int unsigned BIT_ONE  = MW - 2;
  localparam int unsigned BIT_LSB  = BIT_ONE - FP_MANT_WIDTH;
  localparam int unsigned BIT_G    = BIT_LSB - 1;
  localparam int unsigned BIT_R    = BIT_LSB - 2;
  localparam int unsigned BIT_STKY = BIT_LSB - 3;
  localparam int          EXP_INF  = 255;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} normState;

  normState                state;
  logic                    signReg;
  logic signed [EW-1:0]    expReg;
  logic        [MW-1:0]    mantReg;
  logic        [CW-1:0]    shiftCnt;
  logic                    zeroFlag;

  // Rounding and range handling, evaluated from the normalized registers.
  logic signed [EW-1:0]            expNorm;
  logic signed [EW-1:0]            expRound;
  logic                            guardBit;
  logic                            roundBit;
  logic                            stickyBit;
  logic                            roundInc;
  logic [FP_MANT_WIDTH:0]          fracSum;
  logic [FP_MANT_WIDTH-1:0]        fracRound;
  logic [31:0]                     resultC;
  logic                            overflowC;
  logic                            underflowC;
  logic                            inexactC;

  always_comb begin
    expNorm    = expReg - EW'(shiftCnt);
    guardBit   = mantReg[BIT_G];
    roundBit   = mantReg[BIT_R];
    // Everything below the round bit folds into sticky, including any bit
    // dragged down by the right shift.
    stickyBit  = |mantReg[BIT_STKY:0];
    roundInc   = guardBit & (roundBit | stickyBit | mantReg[BIT_LSB]);
    fracSum    = {1'b0, mantReg[BIT_ONE-1:BIT_LSB]} + (FP_MANT_WIDTH+1)'(roundInc);
    // Fraction carry-out: significand became 2.0, so bump exponent, clear fraction.
    expRound   = expNorm + EW'(fracSum[FP_MANT_WIDTH]);
    fracRound  = fracSum[FP_MANT_WIDTH] ? '0 : fracSum[FP_MANT_WIDTH-1:0];
    resultC    = '0;
    overflowC  = 1'b0;
    underflowC = 1'b0;
    inexactC   = 1'b0;
    if (!zeroFlag) begin
      inexactC = guardBit | roundBit | stickyBit;
      if (int'(expRound) >= EXP_INF) begin
        resultC   = {signReg, {FP_EXP_WIDTH{1'b1}}, {FP_MANT_WIDTH{1'b0}}};
        overflowC = 1'b1;
      end else if (int'(expRound) <= 0) begin
        resultC    = {signReg, {(FP_EXP_WIDTH + FP_MANT_WIDTH){1'b0}}};
        underflowC = 1'b1;
      end else begin
        resultC = {signReg, expRound[FP_EXP_WIDTH-1:0], fracRound};
      end
    end
  end

`ifdef VFPU_NORM_LZC_EN
  // Distance from the leading one (below bit 46) up to bit 46.
  logic [CW-1:0] lzcCount;

  always_comb begin
    lzcCount = '0;
    for (int i = 0; i < int'(BIT_ONE); i++) begin
      if (mantReg[i]) lzcCount = CW'(int'(BIT_ONE) - i);
    end
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      signReg     <= 1'b0;
      expReg      <= '0;
      mantReg     <= '0;
      shiftCnt    <= '0;
      zeroFlag    <= 1'b0;
      ready_o     <= 1'b1;
      valid_o     <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      inexact_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            signReg  <= signPreNorm_i;
            expReg   <= {{(EW - FP_EXP_PRENORM_WIDTH){exponentPreNorm_i[FP_EXP_PRENORM_WIDTH-1]}},
                         exponentPreNorm_i};
            mantReg  <= mantissaPreNorm_i;
            shiftCnt <= '0;
            zeroFlag <= 1'b0;
            ready_o  <= 1'b0;
            state    <= NORM;
          end
        end

        NORM: begin
          if (mantReg == '0) begin
            zeroFlag <= 1'b1;
            state    <= ROUND;
          end else if (mantReg[BIT_CRY]) begin
            // Keep the bit shifted out of position 0 alive as sticky.
            mantReg <= {1'b0, mantReg[MW-1:2], mantReg[1] | mantReg[0]};
            expReg  <= expReg + EW'(1);
            state   <= ROUND;
          end else if (mantReg[BIT_ONE]) begin
            state <= ROUND;
          end else begin
`ifdef VFPU_NORM_LZC_EN
            mantReg  <= mantReg << lzcCount;
            shiftCnt <= lzcCount;
            state    <= ROUND;
`else
            // One bit per cycle; leave once this shift lands the leading one.
            mantReg  <= {mantReg[MW-2:0], 1'b0};
            shiftCnt <= shiftCnt + CW'(1);
            if (mantReg[BIT_ONE-1]) state <= ROUND;
`endif
          end
        end

        ROUND: begin
          result_o    <= resultC;
          overflow_o  <= overflowC;
          underflow_o <= underflowC;
          inexact_o   <= inexactC;
          valid_o     <= 1'b1;
          state       <= OUT;
        end

        OUT: begin
          if (ready_i) begin
            valid_o     <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
            ready_o     <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfpu_norm.sv
// Self-checking bench for vfpu_norm: directed vector table, backpressure and
// mid-flight reset sequences, then random operands against a numeric model.
module tb_vfpu_norm;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic        signPreNorm_i;
  logic signed [9:0]  exponentPreNorm_i;
  logic [47:0] mantissaPreNorm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  int passCnt = 0;
  int checkCnt = 0;

  vfpu_norm dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .signPreNorm_i     (signPreNorm_i),
    .exponentPreNorm_i (exponentPreNorm_i),
    .mantissaPreNorm_i (mantissaPreNorm_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .result_o          (result_o),
    .overflow_o        (overflow_o),
    .underflow_o       (underflow_o),
    .inexact_o         (inexact_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string              name;
    logic               sgn;
    logic signed [9:0]  exp;
    logic [47:0]        mant;
    logic [31:0]        res;
    logic [2:0]         flags;   // {overflow, underflow, inexact}
    int                 normCyc; // NORM cycles in the bit-serial build
  } vecT;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checkCnt++;
    if (act === expv) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic int latOf(input int normCyc);
`ifdef VFPU_NORM_LZC_EN
    latOf = 3 + 0 * normCyc;
`else
    latOf = 2 + normCyc;
`endif
  endfunction

  // Numeric reference: value = m * 2^(e-127-46); normalize to [2^46, 2^47),
  // round the 24-bit significand to nearest-even, then classify the range.
  function automatic void refModel(input logic sgn, input int e0, input longint unsigned m0,
                                   output logic [31:0] res, output logic [2:0] flags,
                                   output int normCyc);
    longint unsigned m, kept, rem;
    int e;
    m = m0; e = e0; normCyc = 1; flags = 3'b000; res = 32'h0;
    if (m == 0) return;
    if (m >= 64'h8000_0000_0000) begin
      m = (m >> 1) | (m & 64'h1);
      e++;
    end else if (m < 64'h4000_0000_0000) begin
      normCyc = 0;
      while (m < 64'h4000_0000_0000) begin
        m = m << 1; e--; normCyc++;
      end
    end
    kept = m >> 23;
    rem  = m & 64'h7F_FFFF;
    if (rem > 64'h40_0000 || (rem == 64'h40_0000 && kept[0])) kept++;
    if (kept == 64'h100_0000) begin
      kept = 64'h80_0000;
      e++;
    end
    flags[0] = (rem != 0);
    if (e >= 255) begin
      res = {sgn, 8'hFF, 23'h0};
      flags[2] = 1'b1;
    end else if (e <= 0) begin
      res = {sgn, 31'h0};
      flags[1] = 1'b1;
    end else begin
      res = {sgn, 8'(e), kept[22:0]};
    end
  endfunction

  task automatic applyOperand(input logic sgn, input logic signed [9:0] e, input logic [47:0] m);
    int guardCnt;
    guardCnt = 0;
    while (!ready_o && guardCnt < 100) begin
      @(posedge clk); #1; guardCnt++;
    end
    if (guardCnt == 100) check("ready_wait_timeout", 64'(ready_o), 64'h1);
    valid_i = 1'b1;
    signPreNorm_i = sgn;
    exponentPreNorm_i = e;
    mantissaPreNorm_i = m;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      cycles++;
    end while (!valid_o && cycles < 200);
  endtask

  task automatic runOp(input string name, input logic sgn, input logic signed [9:0] e,
                       input logic [47:0] m, input logic [31:0] expRes,
                       input logic [2:0] expFlags, input int expLat);
    int cycles;
    applyOperand(sgn, e, m);
    waitValid(cycles);
    check({name, "_latency"}, 64'(cycles), 64'(expLat));
    check({name, "_result"}, 64'(result_o), 64'(expRes));
    check({name, "_flags"}, 64'({overflow_o, underflow_o, inexact_o}), 64'(expFlags));
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({name, "_idle_after"}, 64'({ready_o, valid_o, overflow_o, underflow_o, inexact_o}),
          64'(5'b10000));
  endtask

  vecT vecs[13];

  initial begin
    logic [31:0] res;
    logic [2:0]  flags;
    int          normCyc;
    int          cycles;
    logic [63:0] r;
    logic [47:0] m;
    logic signed [9:0] e;
    logic        sgn;

    vecs[0]  = '{"one_plus_one",  1'b0, 10'sd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000, 1};
    vecs[1]  = '{"cancel23",      1'b0, 10'sd127, 48'h0000_0080_0000, 32'h3400_0000, 3'b000, 23};
    vecs[2]  = '{"tie_even_down", 1'b0, 10'sd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001, 1};
    vecs[3]  = '{"tie_odd_up",    1'b0, 10'sd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001, 1};
    vecs[4]  = '{"overflow_pos",  1'b0, 10'sd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b100, 1};
    vecs[5]  = '{"overflow_neg",  1'b1, 10'sd254, 48'h8000_0000_0000, 32'hFF80_0000, 3'b100, 1};
    vecs[6]  = '{"zero",          1'b1, 10'sd100, 48'h0,              32'h0000_0000, 3'b000, 1};
    vecs[7]  = '{"underflow_shl", 1'b1, 10'sd1,   48'h2000_0000_0000, 32'h8000_0000, 3'b010, 1};
    vecs[8]  = '{"round_carry",   1'b0, 10'sd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001, 1};
    vecs[9]  = '{"round_to_inf",  1'b0, 10'sd254, 48'h7FFF_FFC0_0000, 32'h7F80_0000, 3'b101, 1};
    vecs[10] = '{"shr_round_up",  1'b0, 10'sd127, 48'h8000_0180_0000, 32'h4000_0002, 3'b001, 1};
    vecs[11] = '{"neg_exp",       1'b1, -10'sd5,  48'h4000_0000_0000, 32'h8000_0000, 3'b010, 1};
    vecs[12] = '{"cancel22",      1'b0, 10'sd130, 48'h0000_0100_0000, 32'h3600_0000, 3'b000, 22};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    signPreNorm_i = 1'b0; exponentPreNorm_i = '0; mantissaPreNorm_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({ready_o, valid_o, overflow_o, underflow_o, inexact_o}), 64'(5'b10000));
    check("reset_result", 64'(result_o), 64'h0);
    rst_i = 1'b0;

    // Directed vectors
    for (int i = 0; i < 13; i++)
      runOp(vecs[i].name, vecs[i].sgn, vecs[i].exp, vecs[i].mant, vecs[i].res,
            vecs[i].flags, latOf(vecs[i].normCyc));

    // Backpressure: result held for 5 cycles, valid_i pulses ignored.
    applyOperand(1'b0, 10'sd127, 48'h4000_0040_0000);
    waitValid(cycles);
    check("bp_latency", 64'(cycles), 64'(latOf(1)));
    for (int k = 0; k < 5; k++) begin
      valid_i = k[0];
      mantissaPreNorm_i = 48'h8000_0000_0000;
      exponentPreNorm_i = 10'sd200;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k),
            64'({valid_o, ready_o, result_o, overflow_o, underflow_o, inexact_o}),
            64'({1'b1, 1'b0, 32'h3F80_0000, 3'b001}));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("bp_release", 64'({ready_o, valid_o}), 64'(2'b10));
    // Nothing may have been captured while busy.
    repeat (30) @(posedge clk);
    #1;
    check("bp_no_ghost", 64'({ready_o, valid_o}), 64'(2'b10));

    // Reset while NORM is working on a long cancellation.
    applyOperand(1'b0, 10'sd127, 48'h0000_0080_0000);
    @(posedge clk); #1;
    valid_i = 1'b0;
`ifndef VFPU_NORM_LZC_EN
    repeat (10) @(posedge clk);
    #1;
`endif
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_norm_state", 64'({ready_o, valid_o, overflow_o, underflow_o, inexact_o}), 64'(5'b10000));
    check("rst_norm_result", 64'(result_o), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    check("rst_norm_discard", 64'({ready_o, valid_o}), 64'(2'b10));
    runOp("after_reset", 1'b0, 10'sd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000, latOf(1));

    // Random operands against the numeric model
    for (int i = 0; i < 200; i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: m = r[47:0];
        1: m = r[47:0] >> $urandom_range(1, 47);
        2: m = ($urandom_range(0, 4) == 0) ? 48'h0 : (48'h1 << $urandom_range(0, 47));
        default: m = {r[47:20], 20'h0};
      endcase
      case ($urandom_range(0, 3))
        0: e = 10'($urandom);
        1: e = 10'(123 + $urandom_range(0, 8));
        2: e = 10'($urandom_range(0, 6));
        default: e = 10'($urandom_range(250, 256));
      endcase
      sgn = 1'($urandom_range(0, 1));
      refModel(sgn, int'(e), longint'(m), res, flags, normCyc);
      runOp($sformatf("rand%0d", i), sgn, e, m, res, flags, latOf(normCyc));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
